// File: rtl/nios_ii_system_pio_in_irq_if.sv
// Avalon-MM slave port bundle for the input PIO: word address, select, write strobe and data,
// plus the registered read data returned to the interconnect.
interface nios_ii_system_pio_in_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_ii_system_pio_in_irq.sv
// Avalon-MM input PIO: synchronises in_port, captures per-bit edges into a sticky
// register and raises a level IRQ for captured bits that are enabled in irqmask.
module nios_ii_system_pio_in_irq #(
    parameter int          WIDTH       = 5,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 0,
    parameter int          BIT_CLEAR   = 1,
    parameter logic [31:0] IRQ_RESET   = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    nios_ii_system_pio_in_irq_if.slave bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      readdata_next;
    logic             write_en;
    logic             unused_writedata;

    // Upper writedata bits are intentionally ignored when WIDTH < 32.
    assign unused_writedata = ^bus.writedata;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync_q = in_port;
        end else begin : g_sync
            logic [WIDTH-1:0] chain [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        chain[i] <= '0;
                    end
                end else begin
                    chain[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign sync_q = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = sync_q & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~sync_q & prev_q;
        end else begin
            edge_det = sync_q ^ prev_q;
        end
    end

    assign write_en = bus.chipselect & ~bus.write_n;

    always_comb begin
        clear_mask = '0;
        if (write_en && bus.address == ADDR_EDGE) begin
            if (BIT_CLEAR != 0) begin
                clear_mask = bus.writedata[WIDTH-1:0];
            end else begin
                clear_mask = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= IRQ_RESET[WIDTH-1:0];
        end else if (write_en && bus.address == ADDR_MASK) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // A new edge wins over a same-cycle clear so no event is ever dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clear_mask) | edge_det;
        end
    end

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = sync_q;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irqmask;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edgecapture;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= readdata_next;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule
